// File: rtl/fp_norm_round_pipe.sv
// fp_norm_round_pipe: normalize, round-to-nearest-even and pack stage of the pipelined FP adder
// Ports: clk/rst (sync, active-high); in_valid/in_ready with in_sign, in_exp[7:0],
// in_mant[24:0] (bit 24 carry, bit 23 hidden), in_grs[2:0] = {G,R,S};
// out_valid/out_ready with out_result[31:0] = {sign,exp,frac} and out_flags[2:0] = {ovf,unf,inexact}.
module fp_norm_round_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [24:0] in_mant,
    input  logic [2:0]  in_grs,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [2:0]  out_flags
);
    logic        w_adv;
    logic [4:0]  w_lzc;
    logic        w_carry;
    logic        w_zero;
    logic [23:0] w_s1_mant;
    logic        w_s1_g;
    logic        w_s1_r;
    logic        w_s1_s;
    logic [8:0]  w_s1_exp;
    logic        r_s1_valid;
    logic        r_s1_sign;
    logic        r_s1_zero;
    logic        r_s1_g;
    logic        r_s1_r;
    logic        r_s1_s;
    logic [8:0]  r_s1_exp;
    logic [23:0] r_s1_mant;
    logic [4:0]  r_s1_lzc;
    logic [25:0] w_s2_win;
    logic        w_s2_flush;
    logic [8:0]  w_s2_exp;
    logic        r_s2_valid;
    logic        r_s2_sign;
    logic        r_s2_zero;
    logic        r_s2_flush;
    logic        r_s2_g;
    logic        r_s2_r;
    logic        r_s2_s;
    logic [8:0]  r_s2_exp;
    logic [23:0] r_s2_mant;
    logic        w_s3_up;
    logic [24:0] w_s3_sum;
    logic [8:0]  w_s3_exp;
    logic        w_s3_ovf;
    logic        w_s3_inexact;
    logic [31:0] w_s3_result;
    logic [2:0]  w_s3_flags;

    assign w_adv    = ~out_valid | out_ready;
    assign in_ready = w_adv;

    // Carry path shifts right by one here; the no-carry path only counts
    // leading zeros and leaves the left shift to the next stage.
    always_comb begin
        w_lzc = 5'd24;
        for (int i = 0; i < 24; i++) w_lzc = in_mant[i] ? 5'(23 - i) : w_lzc;
        w_carry   = in_mant[24];
        w_zero    = (in_mant == 25'd0) && (in_grs == 3'd0);
        w_s1_mant = w_carry ? in_mant[24:1] : in_mant[23:0];
        w_s1_g    = w_carry ? in_mant[0] : in_grs[2];
        w_s1_r    = w_carry ? in_grs[2] : in_grs[1];
        w_s1_s    = w_carry ? |in_grs[1:0] : in_grs[0];
        w_s1_exp  = {1'b0, in_exp} + {8'd0, w_carry};
    end

    // A zero shift on the carry path lets both paths share the shifter, and
    // since its exponent is at least 1 it can never trip the flush test.
    always_comb begin
        w_s2_win   = {r_s1_mant, r_s1_g, r_s1_r} << r_s1_lzc;
        w_s2_flush = ~r_s1_zero & (r_s1_exp <= {4'd0, r_s1_lzc});
        w_s2_exp   = r_s1_exp - {4'd0, r_s1_lzc};
    end

    // Rounding carry out of 24 bits leaves sum[22:0] = 0, which is exactly
    // the fraction of 1.0 after bumping the exponent.
    always_comb begin
        w_s3_up      = r_s2_g & (r_s2_r | r_s2_s | r_s2_mant[0]);
        w_s3_sum     = {1'b0, r_s2_mant} + {24'd0, w_s3_up};
        w_s3_exp     = r_s2_exp + {8'd0, w_s3_sum[24]};
        w_s3_ovf     = w_s3_exp >= 9'd255;
        w_s3_inexact = r_s2_g | r_s2_r | r_s2_s;
        w_s3_result  = r_s2_zero  ? 32'd0 :
                       r_s2_flush ? {r_s2_sign, 31'd0} :
                       w_s3_ovf   ? {r_s2_sign, 8'hFF, 23'd0} :
                                    {r_s2_sign, w_s3_exp[7:0], w_s3_sum[22:0]};
        w_s3_flags   = r_s2_zero  ? 3'b000 :
                       r_s2_flush ? 3'b011 :
                       w_s3_ovf   ? 3'b101 : {2'b00, w_s3_inexact};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= 32'd0;
            out_flags  <= 3'd0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            r_s1_sign  <= in_sign;
            r_s1_zero  <= w_zero;
            r_s1_g     <= w_s1_g;
            r_s1_r     <= w_s1_r;
            r_s1_s     <= w_s1_s;
            r_s1_exp   <= w_s1_exp;
            r_s1_mant  <= w_s1_mant;
            r_s1_lzc   <= w_carry ? 5'd0 : w_lzc;
            r_s2_valid <= r_s1_valid;
            r_s2_sign  <= r_s1_sign;
            r_s2_zero  <= r_s1_zero;
            r_s2_flush <= w_s2_flush;
            r_s2_g     <= w_s2_win[1];
            r_s2_r     <= w_s2_win[0];
            r_s2_s     <= r_s1_s;
            r_s2_exp   <= w_s2_exp;
            r_s2_mant  <= w_s2_win[25:2];
            out_valid  <= r_s2_valid;
            if (r_s2_valid) begin
                out_result <= w_s3_result;
                out_flags  <= w_s3_flags;
            end
        end
    end
endmodule

// File: tb/tb_fp_norm_round_pipe.sv
// tb_fp_norm_round_pipe: directed vectors, stall/reset sequences and random traffic against a reference model
module tb_fp_norm_round_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = 8'd0;
    logic [24:0] in_mant = 25'd0;
    logic [2:0]  in_grs = 3'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [2:0]  out_flags;

    int checks = 0;
    int errors = 0;
    int delivered = 0;
    logic [34:0] exp_q[$];

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [24:0] mant;
        logic [2:0]  grs;
        logic [31:0] res;
        logic [2:0]  flg;
    } vec_t;

    vec_t tv [14];

    fp_norm_round_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_grs(in_grs),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags)
    );

    always #5 clk = ~clk;

    // Value-level model: normalize so the leading one sits at the hidden bit,
    // round the discarded fraction to nearest (ties to even), then pack.
    function automatic logic [34:0] model(input logic sgn, input logic [7:0] ex,
                                          input logic [24:0] mant, input logic [2:0] grs);
        longint m;
        longint q;
        int lz;
        int e;
        int rem;
        logic up;
        if (mant == 25'd0 && grs == 3'd0) return 35'd0;
        if (mant[24]) begin
            m   = longint'(mant) / 2;
            rem = 4 * int'(mant[0]) + 2 * int'(grs[2]) + int'(grs[1] | grs[0]);
            e   = int'(ex) + 1;
        end else begin
            lz = 0;
            while (lz < 24 && longint'(mant[23:0]) < (64'sd1 << (23 - lz))) lz++;
            if (int'(ex) <= lz) return {sgn, 31'd0, 3'b011};
            q   = (longint'({mant[23:0], grs[2:1]}) << lz) % (64'sd1 << 26);
            m   = q / 4;
            rem = 2 * int'(q % 4) + int'(grs[0]);
            e   = int'(ex) - lz;
        end
        up = (rem > 4) || (rem == 4 && (m % 2) == 1);
        m = m + (up ? 64'sd1 : 64'sd0);
        if (m == (64'sd1 << 24)) begin
            m = 64'sd1 << 23;
            e++;
        end
        if (e >= 255) return {sgn, 8'hFF, 23'd0, 3'b101};
        return {sgn, e[7:0], m[22:0], 2'b00, rem != 0};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Handshakes are judged mid-cycle: inputs only change just after posedge.
    always @(negedge clk) begin
        if (rst) exp_q.delete();
        else begin
            if (out_valid && out_ready) begin
                delivered++;
                if (exp_q.size() == 0) chk("unexpected_result", {29'd0, out_result, out_flags}, 64'hDEAD);
                else chk("scoreboard", {29'd0, out_result, out_flags}, {29'd0, exp_q.pop_front()});
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_sign, in_exp, in_mant, in_grs));
        end
    end

    task automatic send(input logic s, input logic [7:0] e, input logic [24:0] m, input logic [2:0] g);
        int w = 0;
        logic ok = 1'b0;
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = e;
        in_mant  = m;
        in_grs   = g;
        while (!ok && w < 50) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            w++;
        end
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        int n;
        int k;
        int d0;
        int vcount;
        logic [34:0] held;
        tv[0]  = '{1'b0, 8'd127, 25'h1000000, 3'b000, 32'h40000000, 3'b000};
        tv[1]  = '{1'b0, 8'd130, 25'h0000001, 3'b000, 32'h35800000, 3'b000};
        tv[2]  = '{1'b0, 8'd127, 25'h0800001, 3'b100, 32'h3F800002, 3'b001};
        tv[3]  = '{1'b0, 8'd127, 25'h0800000, 3'b100, 32'h3F800000, 3'b001};
        tv[4]  = '{1'b1, 8'd254, 25'h1FFFFFF, 3'b111, 32'hFF800000, 3'b101};
        tv[5]  = '{1'b0, 8'd3,   25'h0000010, 3'b000, 32'h00000000, 3'b011};
        tv[6]  = '{1'b0, 8'd100, 25'h0000000, 3'b000, 32'h00000000, 3'b000};
        tv[7]  = '{1'b1, 8'd50,  25'h0000000, 3'b000, 32'h00000000, 3'b000};
        tv[8]  = '{1'b0, 8'd127, 25'h0FFFFFF, 3'b110, 32'h40000000, 3'b001};
        tv[9]  = '{1'b0, 8'd254, 25'h0FFFFFF, 3'b100, 32'h7F800000, 3'b101};
        tv[10] = '{1'b1, 8'd23,  25'h0000001, 3'b000, 32'h80000000, 3'b011};
        tv[11] = '{1'b0, 8'd24,  25'h0000001, 3'b000, 32'h00800000, 3'b000};
        tv[12] = '{1'b0, 8'd127, 25'h1000001, 3'b000, 32'h40000000, 3'b001};
        tv[13] = '{1'b0, 8'd127, 25'h1000003, 3'b000, 32'h40000002, 3'b001};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_result", out_result, 0);
        chk("reset_out_flags", out_flags, 0);
        chk("reset_in_ready", in_ready, 1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) begin
            in_valid  = 1'b1;
            in_sign   = tv[i].sign;
            in_exp    = tv[i].exp;
            in_mant   = tv[i].mant;
            in_grs    = tv[i].grs;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            n = 1;
            while (!out_valid && n < 10) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk($sformatf("vec%0d_latency", i), n, 3);
            chk($sformatf("vec%0d_result", i), out_result, tv[i].res);
            chk($sformatf("vec%0d_flags", i), out_flags, tv[i].flg);
            @(posedge clk);
            #1;
        end

        d0 = delivered;
        fork
            begin
                for (int b = 0; b < 4; b++) send(1'b0, 8'(120 + b), 25'h0800000 + 25'(b * 3), 3'(b));
            end
            begin
                int w = 0;
                while (!out_valid && w < 20) begin
                    @(posedge clk);
                    #1;
                    w++;
                end
                chk("bp_valid_seen", out_valid, 1);
                out_ready = 1'b0;
                held = {out_result, out_flags};
                for (int c = 0; c < 2; c++) begin
                    @(negedge clk);
                    chk("bp_in_ready_low", in_ready, 0);
                    chk("bp_out_valid_held", out_valid, 1);
                    chk("bp_output_stable", {29'd0, out_result, out_flags}, {29'd0, held});
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp_delivered", delivered - d0, 4);

        send(1'b0, 8'd127, 25'h1000000, 3'b000);
        send(1'b1, 8'd130, 25'h0400000, 3'b010);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid_next", out_valid, 0);
        vcount = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid) vcount++;
        end
        chk("rst_no_stale", vcount, 0);
        @(posedge clk);
        #1;

        for (int c = 0; c < 1500; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 8);
            in_sign   = 1'($urandom);
            k         = $urandom_range(0, 25);
            in_mant   = (k == 0) ? 25'd0 : 25'($urandom >> (32 - k));
            in_exp    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(240, 254)) : 8'($urandom_range(0, 254));
            in_grs    = 3'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp_norm_round_pipe.md
Name: fp_norm_round_pipe

Overview:
- Post-add normalize/round back end of the pipelined single-precision FP adder.
- Consumes the raw sum from the right-shift alignment/add path: 25-bit magnitude with carry, guard/round/sticky, and the larger exponent.
- Renormalizes (right by 1 on carry, or left by leading-zero count), rounds to nearest even, and packs an IEEE-754 word.
- 3-stage pipeline with a valid/ready handshake.

Parameters:
- none; fixed to single precision: 8-bit exponent, 24-bit significand.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts the beat this cycle.
- in_sign  in  1  result sign.
- in_exp  in  8  biased exponent of the larger operand.
- in_mant  in  25  sum magnitude; bit 24 is carry-out, bit 23 is the hidden-bit position.
- in_grs  in  3  guard, round, sticky ([2]=G, [1]=R, [0]=S).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_result  out  32  packed {sign, exp[7:0], frac[22:0]}.
- out_flags  out  3  [2]=overflow, [1]=underflow, [0]=inexact.

Behaviour:
- Reset: all stage valid bits cleared; out_valid=0, out_result=0, out_flags=0. Reset during operation discards every in-flight beat. out_valid is 0 in the cycle after rst is sampled high.
- Advance: adv = ~out_valid | out_ready; in_ready = adv. When adv=1, all stages shift one place. When adv=0, every stage register holds, and out_result/out_flags remain stable while out_valid=1.
- A beat is accepted when in_valid & in_ready. Latency is 3 clk edges from acceptance to out_valid with no stall. Throughput is 1 beat/cycle. Order is preserved.
- S1 carry path, when in_mant[24]=1:
  - m = in_mant[24:1].
  - G = in_mant[0], R = in_grs[2], S = in_grs[1] | in_grs[0].
  - e = in_exp + 1 (9-bit).
- S1 no-carry path: lzc = leading-zero count of in_mant[23:0], range 0..24. G/R/S pass through.
- S1 zero: when in_mant == 0 and in_grs == 0, set a zero flag. The result is +0 (0x00000000) with all flags 0.
- S2 left shift, no-carry path:
  - W = {in_mant[23:0], G, R}, a 26-bit vector, shifted left by lzc with zero fill.
  - m = W[25:2], G = W[1], R = W[0]; S is unchanged.
  - e = in_exp - lzc.
  - If in_exp <= lzc on a nonzero input: flush to signed zero {in_sign, 31'b0} with underflow=1 and inexact=1.
- S3 round (RNE):
  - up = G & (R | S | m[0]).
  - m' = m + up.
  - If m' overflows 24 bits: m' = 24'h800000 and e = e + 1.
  - inexact = G | R | S.
- S3 overflow: if e >= 255 after S1 or S3, result is {sign, 8'hFF, 23'b0} with overflow=1 and inexact=1.
- S3 pack: {sign, e[7:0], m'[22:0]}.
- Input in_exp is never 255 on valid beats; NaN/Inf bypass handling lives upstream.
- Flags are registered with out_result and share out_valid.

Test Plan:
- 1.0+1.0: in_exp=127, in_mant=25'h1000000, in_grs=0 → 3 cycles later out_result=32'h40000000, out_flags=3'b000.
- Cancellation: in_exp=130, in_mant=25'h0000001, in_grs=0 → lzc=23, out_result=32'h35800000, flags=0.
- RNE rounding, two checks:
  - in_exp=127, in_mant=25'h0800001, in_grs=3'b100 → 32'h3F800002, inexact=1.
  - Same inputs with in_mant=25'h0800000 → 32'h3F800000, inexact=1.
- Overflow, two checks:
  - in_sign=1, in_exp=254, in_mant=25'h1FFFFFF, in_grs=3'b111 → 32'hFF800000, flags=3'b101.
  - Underflow: in_exp=3, in_mant=25'h0000010 → 32'h00000000 (sign 0), flags=3'b011.
- Zero: in_mant=0, in_grs=0 → 32'h00000000, flags=0.
- Backpressure and reset:
  - Send 4 back-to-back beats; drop out_ready for 2 cycles once out_valid=1 → in_ready=0 during the stall, out_result stable, all 4 results delivered in order with none lost or duplicated.
  - Then assert rst with 2 beats in flight → out_valid=0 next cycle, and no stale results appear afterwards.
